rr_mem_scheduler: RTL and testbench
===================================

Name: rr_mem_scheduler

Overview:
- Shares one single-outstanding memory port between N requesters using round-robin arbitration.
- Grant is held for a whole transaction: issue handshake plus response.
- The RR pointer advances only when the memory port accepts the request.
- Sits between the requester agents and the shared memory/bus port.

Parameters:
- N, 4: number of requesters (>=2).
- AW, 16: address width.
- DW, 32: data width.
- TIMEOUT, 15: max cycles in WAIT_RESP before abort (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level.
- we  in  N  per-requester op: 1=write, 0=read.
- addr  in  N*AW  packed per-requester address; slice i = [i*AW +: AW].
- wdata  in  N*DW  packed per-requester write data.
- grant  out  N  one-hot; owner of the in-flight transaction.
- done  out  N  one-cycle completion pulse to the owner.
- err  out  N  one-cycle timeout pulse to the owner.
- rdata  out  DW  read data, valid when done is high for a read.
- busy  out  1  high whenever state != IDLE.
- mem_valid  out  1  request valid to the memory port.
- mem_we  out  1  latched op.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_ready  in  1  memory accepts the request when mem_valid && mem_ready.
- mem_rvalid  in  1  response strobe; reads and writes both receive one.
- mem_rdata  in  DW  response data.

Behaviour:
- Reset (async, resetN=0): state=IDLE; grant, done, err, rdata, mem_* outputs, timeout counter = 0; pointer = N-1, so requester 0 has first priority. Reset mid-transaction abandons it; any later mem_rvalid is ignored.
- Effective request: eff = req & ~done. A requester whose done pulse is high this cycle is excluded from arbitration.
- Selection (combinational):
  - Masked set = eff bits with index > pointer; pick the lowest-index set bit.
  - If the masked set is empty, pick the lowest-index set bit of eff.
- IDLE:
  - If eff != 0: register grant = one-hot winner; latch we/addr/wdata of the winner into mem_we/mem_addr/mem_wdata; set mem_valid=1; go to ISSUE.
  - Latency: req sampled high at cycle 0 gives grant and mem_valid high in cycle 1.
- ISSUE:
  - mem_valid, mem_we, mem_addr, mem_wdata are held stable until mem_ready.
  - On mem_valid && mem_ready: mem_valid=0; pointer = winner index; counter = 0; go to WAIT_RESP.
  - No timeout in ISSUE.
- WAIT_RESP, counter increments each cycle:
  - On mem_rvalid: done[winner]=1 for one cycle; for reads rdata = mem_rdata (writes leave rdata unchanged); grant=0; go to IDLE.
  - Else if counter == TIMEOUT-1: err[winner]=1 for one cycle; grant=0; go to IDLE.
  - If mem_rvalid and the timeout coincide, mem_rvalid wins.
- mem_rvalid while in IDLE or ISSUE is ignored.
- The grant holder dropping req mid-transaction is ignored; the transaction completes normally.
- Throughput: minimum 3 cycles per transaction (IDLE, ISSUE, WAIT_RESP).
- A requester may re-request in the cycle after its done or err pulse.
- Counter width is $clog2(TIMEOUT+1) and saturates (no wrap).
- Pointer wrap-around: pointer = N-1 means the masked set is empty, so selection is a pure lowest-index pick.

Decomposition:
- Package rr_mem_pkg: state enum (IDLE, ISSUE, WAIT_RESP) and op constants (OP_RD=0, OP_WR=1).
- Sub-module rr_pick #(N): combinational. Inputs eff and pointer; outputs one-hot grant, index and any. Reusable by future arbiters.

Test Plan:
- Reset and single read:
  - Stimulus: resetN low then high; req=4'b0100, addr[2]=16'h1234; mem_ready=1 in cycle 1; mem_rvalid with 32'hDEADBEEF two cycles later.
  - Response: grant=4'b0100 from cycle 1; mem_addr=16'h1234; done=4'b0100 for one cycle; rdata=32'hDEADBEEF; pointer=2.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held; memory always ready with 1-cycle response.
  - Response: grant order 0,1,2,3,0; done on each requester's own bit; no requester granted twice in a row.
- Pointer held until accept:
  - Stimulus: req=4'b0011; mem_ready low for 5 cycles after grant to 0.
  - Response: grant=4'b0001 and mem_* stable all 5 cycles; pointer stays 3 until the accept cycle; the next transaction goes to 1.
- Timeout:
  - Stimulus: TIMEOUT=15, write from requester 1 accepted, no mem_rvalid.
  - Response: err=4'b0010 pulse 15 cycles after accept; done stays 0; state returns to IDLE; a late mem_rvalid is ignored; rdata unchanged.
- Reset mid-transaction:
  - Stimulus: resetN low during WAIT_RESP; release; then mem_rvalid arrives.
  - Response: all outputs 0 immediately on resetN low; no done pulse; next request goes to requester 0 first.
- Simultaneous timeout and response:
  - Stimulus: mem_rvalid arrives in the final timeout cycle.
  - Response: done pulses, err stays 0.

Source files
------------

// File: rtl/rr_mem_pkg.sv
// Shared types for the round-robin memory scheduler.
package rr_mem_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  // Memory operation encoding carried on mem_we
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest set request above the pointer, else lowest overall.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eff,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [N-1:0] masked;
  logic [N-1:0] src;

  // Build the above-pointer mask, fall back to the full set, then pick the lowest index
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = eff[i] && (IW'(i) > ptr);
    end
    src = (|masked) ? masked : eff;
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    any = |eff;
  end

endmodule

// File: rtl/rr_mem_scheduler.sv
// Shares one single-outstanding memory port between N requesters, round-robin.
// Handshake: the request transfers on a cycle where mem_valid && mem_ready;
// mem_valid and its payload (mem_we/mem_addr/mem_wdata) hold steady until then.
// The response is a one-cycle mem_rvalid strobe and is only honoured in WAIT_RESP.
module rr_mem_scheduler
  import rr_mem_pkg::*;
#(
  parameter int N       = 4,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         we,
  input  logic [N*AW-1:0]      addr,
  input  logic [N*DW-1:0]      wdata,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         done,
  output logic [N-1:0]         err,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [DW-1:0]        mem_rdata,
  output state_t               dbg_state,
  output logic [$clog2(N)-1:0] dbg_ptr
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, next_state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    eff;
  logic [N-1:0]    pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            timeout_hit;
  logic            load, accept, resp_ok, resp_to;

  // A requester finishing this cycle sits out the arbitration it would otherwise win again
  assign eff = req & ~done;

  rr_pick #(.N(N)) u_pick (
    .eff (eff),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign dbg_ptr     = ptr;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a response in the last timeout cycle takes precedence
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (pick_any) next_state = ISSUE;
      ISSUE:     if (mem_valid && mem_ready) next_state = WAIT_RESP;
      WAIT_RESP: if (mem_rvalid || timeout_hit) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    load    = (state == IDLE) && pick_any;
    accept  = (state == ISSUE) && mem_valid && mem_ready;
    resp_ok = (state == WAIT_RESP) && mem_rvalid;
    resp_to = (state == WAIT_RESP) && !mem_rvalid && timeout_hit;
  end

  // Registered outputs, pointer and timeout counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= OP_RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      win_idx   <= '0;
      ptr       <= IW'(N - 1);
    end else begin
      done <= '0;
      err  <= '0;
      if (load) begin
        grant     <= pick_gnt;
        win_idx   <= pick_idx;
        mem_valid <= 1'b1;
        mem_we    <= we[pick_idx] ? OP_WR : OP_RD;
        mem_addr  <= addr[pick_idx*AW +: AW];
        mem_wdata <= wdata[pick_idx*DW +: DW];
      end
      if (accept) begin
        mem_valid <= 1'b0;
        ptr       <= win_idx;
        cnt       <= '0;
      end else if ((state == WAIT_RESP) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
      if (resp_ok) begin
        done  <= grant;
        grant <= '0;
        if (mem_we == OP_RD) rdata <= mem_rdata;
      end
      if (resp_to) begin
        err   <= grant;
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mem_scheduler.sv
// Scenario bench for rr_mem_scheduler with a completion scoreboard.
module tb_rr_mem_scheduler;
  import rr_mem_pkg::*;

  localparam int N       = 4;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;
  localparam int W       = 2*N + DW;

  logic              clk = 1'b0;
  logic              resetN;
  logic [N-1:0]      req, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      grant, done, err;
  logic [DW-1:0]     rdata;
  logic              busy, mem_valid, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  state_t            dbg_state;
  logic [1:0]        dbg_ptr;

  logic [W-1:0]      exp_q[$];
  logic [DW-1:0]     model_rdata;
  int                n_vec = 0;
  int                n_err = 0;

  rr_mem_scheduler #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetN(resetN), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; sample point sits 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_rdata = '0;
    exp_q.delete();
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({grant, done, err, rdata, mem_valid, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got grant=%b done=%b err=%b rdata=%h mv=%b addr=%h busy=%b want all zero",
               grant, done, err, rdata, mem_valid, mem_addr, busy);
    end
    n_vec++;
    if (dbg_state !== IDLE || dbg_ptr !== 2'd3) begin
      n_err++;
      $display("FAIL reset_state got state=%0d ptr=%0d want state=0 ptr=3", dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_single_read();
    logic [W-1:0] e;
    do_reset();
    req = 4'b0100; we = '0; addr[2*AW +: AW] = 16'h1234;
    tick();
    n_vec++;
    if (grant !== 4'b0100 || mem_valid !== 1'b1 || mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL read_issue got grant=%b mv=%b addr=%h we=%b want 0100 1 1234 0",
               grant, mem_valid, mem_addr, mem_we);
    end
    req = '0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_vec++;
    if (dbg_ptr !== 2'd2 || mem_valid !== 1'b0 || grant !== 4'b0100 || dbg_state !== WAIT_RESP) begin
      n_err++;
      $display("FAIL read_accept got ptr=%0d mv=%b grant=%b state=%0d want 2 0 0100 2",
               dbg_ptr, mem_valid, grant, dbg_state);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    model_rdata = 32'hDEADBEEF;
    exp_q.push_back({4'b0100, 4'b0000, model_rdata});
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    e = exp_q.pop_front();
    if ({done, err, rdata} !== e) begin
      n_err++;
      $display("FAIL read_resp got done=%b err=%b rdata=%h want done=%b err=%b rdata=%h",
               done, err, rdata, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
    end
    tick();
    n_vec++;
    if (done !== '0 || grant !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL read_pulse got done=%b grant=%b busy=%b want 0 0 0", done, grant, busy);
    end
  endtask

  task automatic test_rr_fairness();
    logic [W-1:0]  e;
    logic [N-1:0]  one, prev, want;
    logic [DW-1:0] d;
    do_reset();
    one = 1; prev = '0;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom_range(0, 65535));
    req = 4'b1111; we = '0; mem_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      want = one << (t % N);
      tick();
      n_vec++;
      if (grant !== want || grant === prev || mem_addr !== addr[(t % N)*AW +: AW]) begin
        n_err++;
        $display("FAIL rr_grant_%0d got grant=%b addr=%h prev=%b want grant=%b addr=%h",
                 t, grant, mem_addr, prev, want, addr[(t % N)*AW +: AW]);
      end
      prev = grant;
      if (t == 4) req = '0;
      tick();
      d = $urandom();
      mem_rvalid = 1'b1; mem_rdata = d;
      model_rdata = d;
      exp_q.push_back({want, 4'b0000, d});
      tick();
      mem_rvalid = 1'b0;
      n_vec++;
      e = exp_q.pop_front();
      if ({done, err, rdata} !== e) begin
        n_err++;
        $display("FAIL rr_resp_%0d got done=%b err=%b rdata=%h want done=%b err=%b rdata=%h",
                 t, done, err, rdata, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_pointer_hold();
    logic [W-1:0]  e;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d;
    do_reset();
    a0 = AW'($urandom_range(0, 65535)); a1 = AW'($urandom_range(0, 65535));
    d0 = $urandom();
    addr[0 +: AW] = a0; addr[AW +: AW] = a1;
    wdata[0 +: DW] = d0;
    we = 4'b0001; req = 4'b0011;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({grant, mem_valid, mem_we, mem_addr, mem_wdata, dbg_ptr, done} !== {4'b0001, 1'b1, 1'b1, a0, d0, 2'd3, 4'b0000}) begin
        n_err++;
        $display("FAIL hold_%0d got grant=%b mv=%b we=%b addr=%h wd=%h ptr=%0d done=%b want 0001 1 1 %h %h 3 0000",
                 k, grant, mem_valid, mem_we, mem_addr, mem_wdata, dbg_ptr, done, a0, d0);
      end
      if (k < 4) begin
        mem_rvalid = (k == 1);
        tick();
        mem_rvalid = 1'b0;
      end
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_vec++;
    if (dbg_ptr !== 2'd0 || mem_valid !== 1'b0 || dbg_state !== WAIT_RESP) begin
      n_err++;
      $display("FAIL hold_accept got ptr=%0d mv=%b state=%0d want 0 0 2", dbg_ptr, mem_valid, dbg_state);
    end
    mem_rvalid = 1'b1; mem_rdata = $urandom();
    exp_q.push_back({4'b0001, 4'b0000, model_rdata});
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    e = exp_q.pop_front();
    if ({done, err, rdata} !== e) begin
      n_err++;
      $display("FAIL hold_wr_resp got done=%b err=%b rdata=%h want done=%b err=%b rdata=%h",
               done, err, rdata, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
    end
    tick();
    n_vec++;
    if (grant !== 4'b0010 || mem_addr !== a1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL hold_next got grant=%b addr=%h we=%b want 0010 %h 0", grant, mem_addr, mem_we, a1);
    end
    req = '0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    d = $urandom();
    mem_rvalid = 1'b1; mem_rdata = d;
    model_rdata = d;
    exp_q.push_back({4'b0010, 4'b0000, d});
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    e = exp_q.pop_front();
    if ({done, err, rdata} !== e || dbg_ptr !== 2'd1) begin
      n_err++;
      $display("FAIL hold_rd_resp got done=%b err=%b rdata=%h ptr=%0d want done=%b err=%b rdata=%h ptr=1",
               done, err, rdata, dbg_ptr, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    do_reset();
    req = 4'b0010; we = 4'b0010;
    addr[AW +: AW] = AW'($urandom_range(0, 65535));
    wdata[DW +: DW] = $urandom();
    mem_ready = 1'b1;
    tick();
    req = '0;
    tick();
    mem_ready = 1'b0;
    exp_q.push_back({4'b0000, 4'b0010, model_rdata});
    for (int m = 1; m < TIMEOUT; m++) begin
      tick();
      n_vec++;
      if (err !== '0 || done !== '0 || dbg_state !== WAIT_RESP) begin
        n_err++;
        $display("FAIL timeout_wait_%0d got err=%b done=%b state=%0d want 0 0 2", m, err, done, dbg_state);
      end
    end
    tick();
    n_vec++;
    e = exp_q.pop_front();
    if ({done, err, rdata} !== e || grant !== '0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL timeout_err got done=%b err=%b rdata=%h grant=%b state=%0d want done=%b err=%b rdata=%h grant=0 state=0",
               done, err, rdata, grant, dbg_state, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
    end
    mem_rvalid = 1'b1; mem_rdata = $urandom();
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    if ({done, err, rdata, busy} !== {4'b0000, 4'b0000, model_rdata, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_late got done=%b err=%b rdata=%h busy=%b want 0 0 %h 0",
               done, err, rdata, busy, model_rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; we = '0; mem_ready = 1'b1;
    tick();
    req = '0;
    tick();
    mem_ready = 1'b0;
    tick();
    resetN = 1'b0;
    model_rdata = '0;
    #1;
    n_vec++;
    if ({grant, done, err, rdata, mem_valid, busy, dbg_ptr} !== {4'b0, 4'b0, 4'b0, 32'h0, 1'b0, 1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL midreset_async got grant=%b done=%b err=%b rdata=%h mv=%b busy=%b ptr=%0d want zeros ptr=3",
               grant, done, err, rdata, mem_valid, busy, dbg_ptr);
    end
    tick();
    resetN = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = $urandom();
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    if (done !== '0 || rdata !== model_rdata || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_stale got done=%b rdata=%h busy=%b want 0 %h 0", done, rdata, busy, model_rdata);
    end
    req = 4'b0101;
    tick();
    req = '0;
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL midreset_first got grant=%b want 0001", grant);
    end
  endtask

  task automatic test_simul_resp_timeout();
    logic [W-1:0]  e;
    logic [DW-1:0] d;
    do_reset();
    req = 4'b0001; we = '0; mem_ready = 1'b1;
    tick();
    req = '0;
    tick();
    mem_ready = 1'b0;
    for (int m = 1; m < TIMEOUT; m++) tick();
    d = $urandom();
    mem_rvalid = 1'b1; mem_rdata = d;
    model_rdata = d;
    exp_q.push_back({4'b0001, 4'b0000, d});
    tick();
    mem_rvalid = 1'b0;
    n_vec++;
    e = exp_q.pop_front();
    if ({done, err, rdata} !== e) begin
      n_err++;
      $display("FAIL simul_resp got done=%b err=%b rdata=%h want done=%b err=%b rdata=%h",
               done, err, rdata, e[W-1 -: N], e[W-N-1 -: N], e[DW-1:0]);
    end
    tick();
    n_vec++;
    if (err !== '0 || done !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL simul_after got err=%b done=%b busy=%b want 0 0 0", err, done, busy);
    end
  endtask

  // Scenario sequence and final report
  initial begin
    resetN = 1'b0;
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_pointer_hold();
    test_timeout();
    test_reset_mid();
    test_simul_resp_timeout();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
